jtframe_scan2x_ctrl: RTL
========================

Name: jtframe_scan2x_ctrl

Overview:
Timing controller that sequences a ping-pong line buffer used for 2x scan doubling. It works from the base-rate pixel enable and the input HS/VS, and measures line length and HS width. It then generates the write side (base rate) and the read side (double rate, each stored line replayed twice), plus the doubled HS and VS. The block sits between the core video timing and the line-buffer RAMs and only reads out once the input line length is stable.

Parameters:
AW, 9, line-buffer address width; maximum line length is 2^AW-1 pixels.
LOCK_LINES, 4, consecutive equal-length lines required before lock.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active high
pxl_cen  in  1  base pixel clock enable
pxl2_cen  in  1  double-rate pixel clock enable
HS  in  1  input horizontal sync, active high
VS  in  1  input vertical sync, active high
wr_en  out  1  line-buffer write strobe
wr_addr  out  AW  write address
wr_bank  out  1  buffer being written
rd_en  out  1  line-buffer read strobe
rd_addr  out  AW  read address
rd_bank  out  1  buffer being read; always ~wr_bank
x2_HS  out  1  doubled HS
x2_VS  out  1  VS re-timed to doubled lines
line_len  out  AW+1  last measured line length in pixels
locked  out  1  line length stable

Behaviour:
- Reset: every output is 0 except rd_bank=1. Lock FSM goes to HUNT. Internal counters clear. Reset asserted mid-line aborts immediately, and the first HS rising edge after release starts a fresh measurement.
- All outputs are registered and become valid one clk after the cen cycle that caused them. The pixel data path feeding the RAM must carry the same one-clk delay.
- HS edges are sampled only on pxl_cen cycles, using the previous HS value captured on pxl_cen.
- Write side, on each pxl_cen:
  - wr_en pulses for one clk.
  - hcnt increments and saturates at 2^AW-1; saturation sets an ovf flag.
  - wr_addr = hcnt.
- HS rising edge tick:
  - line_len <= hcnt+1.
  - hcnt <= 0, and this tick writes address 0.
  - wr_bank toggles.
  - ovf is evaluated, then cleared.
- HS falling edge tick: hs_w <= pixels since the rising edge (hcnt+1), saturating.
- Lock FSM, evaluated at each HS rising tick:
  - HUNT: ref <= new length, match count <= 0, go to CHECK.
  - CHECK: if length == ref, match count increments; when it reaches LOCK_LINES-1, go to LOCK. On a mismatch, ref <= new length, match count <= 0, stay in CHECK.
  - LOCK: a mismatch goes to CHECK, with ref reloaded and match count cleared.
  - ovf in any state goes to HUNT.
  - locked = (state==LOCK).
- Read side, on each pxl2_cen:
  - rd_en pulses only when locked.
  - rdcnt increments; when rdcnt == line_len-1 it wraps to 0, which starts the second replay of the same line.
  - rd_addr = rdcnt.
- An HS rising tick forces rdcnt to 0 and takes priority over a coincident pxl2_cen increment. rd_bank flips with wr_bank in the same cycle.
- While not locked, rdcnt is held at 0, rd_en=0, x2_HS=0 and x2_VS=0.
- x2_HS = locked && hs_w!=0 && rdcnt < hs_w, updated on pxl2_cen. The pulse therefore spans hs_w double-rate pixels at the start of each half-line.
- x2_VS samples VS each time rdcnt is loaded with 0 (wrap or resync), so it changes only on doubled-line boundaries.
- line_len==0 is never produced, since the minimum is 1. line_len==1 makes rdcnt stay at 0.
- If pxl_cen and pxl2_cen are active in the same clk, both sides update independently in that cycle.

Test Plan:
- Reset, then HS period 384 pxl_cen ticks (AW=9) with pxl2_cen at 2x -> line_len=384; locked=1 on the 5th HS rising edge (edge 1 HUNT->CHECK, 3 matches); rd_addr sweeps 0..383 twice per input line; wr_bank toggles each line with rd_bank=~wr_bank.
- HS high for 32 pxl_cen ticks -> x2_HS high for 32 pxl2_cen ticks at rdcnt 0..31, twice per input line.
- Locked at 384, then one line of 383 -> locked drops at that edge; re-locks after 3 further lines of 383, line_len=383.
- HS held low for >511 pixels -> hcnt saturates at 511; next edge goes to HUNT, locked=0; rd_en stays 0 until re-lock.
- HS rising tick coincident with pxl2_cen while rdcnt=200 -> rdcnt=0 next cycle, not 201.
- rst pulsed mid-line while locked -> all outputs 0 and rd_bank=1 next clk; after release, lock requires 5 fresh HS edges.

Source files
------------

// File: rtl/jtframe_scan2x_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : jtframe_scan2x_ctrl_if
//  Description : Bundle between the scan-doubler timing controller and its
//                surroundings.
//                Inputs to the controller:
//                  pxl_cen, pxl2_cen : base and double-rate pixel enables
//                  HS, VS            : input video syncs
//                Outputs from the controller:
//                  wr_en, wr_addr, wr_bank : line-buffer write side
//                  rd_en, rd_addr, rd_bank : line-buffer read side
//                  x2_HS, x2_VS            : doubled syncs
//                  line_len, locked        : line measurement status
//                master = controller side, slave = line buffer / video side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface jtframe_scan2x_ctrl_if #(
    parameter int AW = 9
);
    logic          pxl_cen;
    logic          pxl2_cen;
    logic          HS;
    logic          VS;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          wr_bank;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          rd_bank;
    logic          x2_HS;
    logic          x2_VS;
    logic [AW:0]   line_len;
    logic          locked;

    modport master (
        input  pxl_cen, pxl2_cen, HS, VS,
        output wr_en, wr_addr, wr_bank, rd_en, rd_addr, rd_bank,
               x2_HS, x2_VS, line_len, locked
    );

    modport slave (
        output pxl_cen, pxl2_cen, HS, VS,
        input  wr_en, wr_addr, wr_bank, rd_en, rd_addr, rd_bank,
               x2_HS, x2_VS, line_len, locked
    );
endinterface
`default_nettype wire

// File: rtl/jtframe_scan2x_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : jtframe_scan2x_ctrl
//  Description : Ping-pong line-buffer sequencer for 2x scan doubling.
//                Measures the input line length and HS width at the base
//                pixel rate, writes each line into one bank while the other
//                bank is replayed twice at the double rate, and produces the
//                doubled HS/VS. Read-out only runs once the line length has
//                been stable for LOCK_LINES lines.
//  Ports       : clk, rst (sync, active high)
//                bus : jtframe_scan2x_ctrl_if.master (cens, syncs, write and
//                      read strobes/addresses/banks, x2 syncs, status)
//                All outputs are registered and valid one clk after the
//                enable cycle that caused them; the pixel data path into the
//                RAM must be delayed by one clk to line up with wr_addr.
//                pxl_cen is expected to coincide with a pxl2_cen so that the
//                HS resync tick also reads address 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module jtframe_scan2x_ctrl #(
    parameter int AW         = 9,
    parameter int LOCK_LINES = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    jtframe_scan2x_ctrl_if.master bus
);
    localparam int            CW      = $clog2(LOCK_LINES + 1);
    localparam logic [AW-1:0] C_HMAX  = {AW{1'b1}};
    localparam logic [AW-1:0] C_ONE   = 1;
    localparam logic [AW:0]   C_LONE  = 1;
    localparam logic [CW-1:0] C_MONE  = 1;
    localparam logic [CW-1:0] C_MTGT  = CW'(LOCK_LINES - 1);

    localparam logic [1:0] S_HUNT  = 2'd0;
    localparam logic [1:0] S_CHECK = 2'd1;
    localparam logic [1:0] S_LOCK  = 2'd2;

    logic          r_hs_prev;
    logic [AW-1:0] r_hcnt;
    logic          r_ovf;
    logic [AW-1:0] r_hs_w;
    logic          r_wr_en;
    logic          r_wr_bank;
    logic          r_rd_bank;
    logic [AW:0]   r_line_len;
    logic [1:0]    r_state;
    logic [AW:0]   r_ref;
    logic [CW-1:0] r_match;
    logic          r_locked;
    logic          r_rd_en;
    logic [AW-1:0] r_rdcnt;
    logic          r_x2_hs;
    logic          r_x2_vs;

    logic          w_hs_rise;
    logic          w_hs_fall;
    logic [AW-1:0] w_hcnt_inc;
    logic [AW:0]   w_len_new;
    logic [1:0]    w_state_nxt;
    logic [AW:0]   w_ref_nxt;
    logic [CW-1:0] w_match_nxt;
    logic          w_lock_nxt;
    logic          w_rd_wrap;
    logic          w_rd_load0;
    logic [AW-1:0] w_rd_nxt;

    // Edges are judged only on base-rate ticks against the HS seen on the
    // previous base-rate tick.
    assign w_hs_rise  = bus.pxl_cen &  bus.HS & ~r_hs_prev;
    assign w_hs_fall  = bus.pxl_cen & ~bus.HS &  r_hs_prev;
    assign w_hcnt_inc = (r_hcnt == C_HMAX) ? C_HMAX : r_hcnt + C_ONE;
    assign w_len_new  = {1'b0, r_hcnt} + C_LONE;

    // Lock tracker next state; only moves on an HS rising tick.
    always_comb begin
        w_state_nxt = r_state;
        w_ref_nxt   = r_ref;
        w_match_nxt = r_match;
        if (w_hs_rise) begin
            if (r_ovf) begin
                w_state_nxt = S_HUNT;
                w_match_nxt = '0;
            end else begin
                case (r_state)
                    S_HUNT: begin
                        w_ref_nxt   = w_len_new;
                        w_match_nxt = '0;
                        w_state_nxt = S_CHECK;
                    end
                    S_CHECK: begin
                        if (w_len_new == r_ref) begin
                            w_match_nxt = r_match + C_MONE;
                            if (w_match_nxt >= C_MTGT) w_state_nxt = S_LOCK;
                        end else begin
                            w_ref_nxt   = w_len_new;
                            w_match_nxt = '0;
                        end
                    end
                    S_LOCK: begin
                        if (w_len_new != r_ref) begin
                            w_ref_nxt   = w_len_new;
                            w_match_nxt = '0;
                            w_state_nxt = S_CHECK;
                        end
                    end
                    default: w_state_nxt = S_HUNT;
                endcase
            end
        end
    end

    // The read side follows the lock decision of this very tick so that
    // rd_en/x2 syncs never run one clk past a lock loss.
    assign w_lock_nxt = (w_state_nxt == S_LOCK);
    assign w_rd_wrap  = ({1'b0, r_rdcnt} == (r_line_len - C_LONE));
    assign w_rd_load0 = w_hs_rise | (bus.pxl2_cen & w_rd_wrap);

    // HS resync wins over a coincident double-rate increment.
    always_comb begin
        w_rd_nxt = r_rdcnt;
        if (w_rd_load0)        w_rd_nxt = '0;
        else if (bus.pxl2_cen) w_rd_nxt = r_rdcnt + C_ONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hs_prev  <= 1'b0;
            r_hcnt     <= '0;
            r_ovf      <= 1'b0;
            r_hs_w     <= '0;
            r_wr_en    <= 1'b0;
            r_wr_bank  <= 1'b0;
            r_rd_bank  <= 1'b1;
            r_line_len <= '0;
            r_state    <= S_HUNT;
            r_ref      <= '0;
            r_match    <= '0;
            r_locked   <= 1'b0;
            r_rd_en    <= 1'b0;
            r_rdcnt    <= '0;
            r_x2_hs    <= 1'b0;
            r_x2_vs    <= 1'b0;
        end else begin
            // ---------------- write side ----------------
            r_wr_en <= bus.pxl_cen;
            if (bus.pxl_cen) begin
                r_hs_prev <= bus.HS;
                if (w_hs_rise) begin
                    r_line_len <= w_len_new;
                    r_hcnt     <= '0;
                    r_wr_bank  <= ~r_wr_bank;
                    r_rd_bank  <= r_wr_bank;
                    r_ovf      <= 1'b0;
                end else begin
                    r_hcnt <= w_hcnt_inc;
                    if (w_hcnt_inc == C_HMAX) r_ovf <= 1'b1;
                end
                if (w_hs_fall) r_hs_w <= w_hcnt_inc;
            end

            // ---------------- lock tracker ----------------
            r_state  <= w_state_nxt;
            r_ref    <= w_ref_nxt;
            r_match  <= w_match_nxt;
            r_locked <= w_lock_nxt;

            // ---------------- read side ----------------
            r_rd_en <= bus.pxl2_cen & w_lock_nxt;
            if (!w_lock_nxt) begin
                r_rdcnt <= '0;
                r_x2_hs <= 1'b0;
                r_x2_vs <= 1'b0;
            end else begin
                r_rdcnt <= w_rd_nxt;
                if (bus.pxl2_cen)
                    r_x2_hs <= (r_hs_w != '0) && (w_rd_nxt < r_hs_w);
                // VS only changes where a doubled line starts.
                if (w_rd_load0) r_x2_vs <= bus.VS;
            end
        end
    end

    assign bus.wr_en    = r_wr_en;
    assign bus.wr_addr  = r_hcnt;
    assign bus.wr_bank  = r_wr_bank;
    assign bus.rd_en    = r_rd_en;
    assign bus.rd_addr  = r_rdcnt;
    assign bus.rd_bank  = r_rd_bank;
    assign bus.x2_HS    = r_x2_hs;
    assign bus.x2_VS    = r_x2_vs;
    assign bus.line_len = r_line_len;
    assign bus.locked   = r_locked;
endmodule
`default_nettype wire
